// File: rtl/res_arb_pkg.sv
// Shared definitions for every client of the distance-transform result RAM.
// Arbitration state encoding plus the RAM geometry constants.
package res_arb_pkg;

  localparam int RES_ADDR_W = 14;
  localparam int RES_DATA_W = 8;

  localparam int RES_IMG_W     = 128;
  localparam int RES_IMG_H     = 128;
  localparam int RES_RAM_WORDS = RES_IMG_W * RES_IMG_H;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/res_mem_arbiter.sv
// Round-robin two-master arbiter for the result RAM; grant is combinational, command is registered
// (read data 2 cycles after transfer). Losers stall with gnt low; a lock is force-released after MAX_LOCK cycles.
module res_mem_arbiter
  import res_arb_pkg::*;
#(
  parameter int ADDR_W   = RES_ADDR_W,
  parameter int DATA_W   = RES_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_req,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_gnt,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_req,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_gnt,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic              res_wr,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di,

  output logic              lock_err
);

  localparam int LCW = $clog2(MAX_LOCK);

  arb_state_t       state, state_nxt;
  logic             rr_last, rr_last_nxt;
  logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
  logic             lock_err_nxt;
  logic             cmd_src;

  logic             xfer;
  logic             sel;
  logic             cur_we;
  logic             cur_lock;
  logic             lock_expire;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  // rr_last names the previous winner, so a tie goes to the other requester
  always_comb begin
    req0_gnt = 1'b0;
    req1_gnt = 1'b0;
    case (state)
      FREE: begin
        req0_gnt = req0_req && (!req1_req || rr_last);
        req1_gnt = req1_req && (!req0_req || !rr_last);
      end
      LOCK0:   req0_gnt = req0_req;
      LOCK1:   req1_gnt = req1_req;
      default: ;
    endcase
  end

  assign xfer      = (req0_req && req0_gnt) || (req1_req && req1_gnt);
  assign sel       = req1_req && req1_gnt;
  assign cur_we    = sel ? req1_we    : req0_we;
  assign cur_lock  = sel ? req1_lock  : req0_lock;
  assign cur_addr  = sel ? req1_addr  : req0_addr;
  assign cur_wdata = sel ? req1_wdata : req0_wdata;

  assign lock_expire = (lock_cnt == LCW'(MAX_LOCK - 1));

  always_comb begin
    state_nxt    = state;
    rr_last_nxt  = rr_last;
    lock_cnt_nxt = lock_cnt;
    lock_err_nxt = 1'b0;
    case (state)
      FREE: begin
        if (xfer) begin
          rr_last_nxt = sel;
          if (cur_lock) begin
            state_nxt    = sel ? LOCK1 : LOCK0;
            lock_cnt_nxt = '0;
          end
        end
      end
      LOCK0, LOCK1: begin
        // The expiring cycle still carries the owner's transfer, but ownership ends regardless
        if (lock_expire) begin
          state_nxt    = FREE;
          rr_last_nxt  = (state == LOCK1);
          lock_cnt_nxt = '0;
          lock_err_nxt = 1'b1;
        end else if (xfer && !cur_lock) begin
          state_nxt    = FREE;
          rr_last_nxt  = (state == LOCK1);
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + LCW'(1);
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FREE;
      rr_last  <= 1'b1;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      lock_cnt <= lock_cnt_nxt;
      lock_err <= lock_err_nxt;
    end
  end

  // Address and write data hold across idle cycles; only the strobes drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_wr      <= 1'b0;
      res_rd      <= 1'b0;
      res_addr    <= '0;
      res_do      <= '0;
      cmd_src     <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
    end else begin
      res_wr      <= xfer && cur_we;
      res_rd      <= xfer && !cur_we;
      if (xfer) begin
        res_addr <= cur_addr;
        res_do   <= cur_wdata;
        cmd_src  <= sel;
      end
      req0_rvalid <= res_rd && !cmd_src;
      req1_rvalid <= res_rd && cmd_src;
    end
  end

  assign req0_rdata = res_di;
  assign req1_rdata = res_di;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Randomised and directed bench for res_mem_arbiter against a transaction-level
// model: per-requester queues, an owner/last-winner record and a shadow RAM.
module tb_res_mem_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int MAXL  = 8;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_req, req0_we, req0_lock, req0_gnt, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_req, req1_we, req1_lock, req1_gnt, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          res_wr, res_rd, lock_err;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do, res_di;

  always #5 clk = ~clk;

  res_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .req0_req(req0_req), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_gnt(req0_gnt),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_req(req1_req), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_gnt(req1_gnt),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .res_wr(res_wr), .res_rd(res_rd), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di), .lock_err(lock_err)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 14'h0081) return 8'd5;
    return a[7:0] ^ 8'h5A;
  endfunction

  // RAM attached to the arbiter; cleared to init_val while ram_clr is high
  logic          ram_clr;
  logic [DW-1:0] ram [WORDS];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_val(AW'(i));
    end else begin
      if (res_wr) ram[res_addr] <= res_do;
      if (res_rd) res_di <= ram[res_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model state
  txn_t          q0[$], q1[$];
  logic [DW-1:0] shadow [WORDS];
  int            owner, last, lock_cycles, exp_src;
  logic          exp_wr, exp_rd, exp_err, exp_rv0, exp_rv1;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_do, exp_rdata, pend_rdata;

  function automatic txn_t mk(input logic we, input logic lock,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; lock_cycles = 0; exp_src = 0;
    exp_wr = 0; exp_rd = 0; exp_err = 0; exp_rv0 = 0; exp_rv1 = 0;
    exp_addr = '0; exp_do = '0;
  endtask

  task automatic drive();
    req0_req = (q0.size() > 0);
    req1_req = (q1.size() > 0);
    {req0_we, req0_lock, req0_addr, req0_wdata} = req0_req ? q0[0] : '0;
    {req1_we, req1_lock, req1_addr, req1_wdata} = req1_req ? q1[0] : '0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then retire granted requests
  task automatic step();
    int   win;
    txn_t t;
    logic err_now;
    drive();
    @(negedge clk);
    win = -1;
    if (owner < 0) begin
      if (req0_req && req1_req) win = 1 - last;
      else if (req0_req)        win = 0;
      else if (req1_req)        win = 1;
    end else if (owner == 0 && req0_req) win = 0;
    else if (owner == 1 && req1_req)     win = 1;

    check("gnt0", req0_gnt, win == 0);
    check("gnt1", req1_gnt, win == 1);
    check("res_wr", res_wr, exp_wr);
    check("res_rd", res_rd, exp_rd);
    check("res_addr", res_addr, exp_addr);
    check("res_do", res_do, exp_do);
    check("lock_err", lock_err, exp_err);
    check("rvalid0", req0_rvalid, exp_rv0);
    check("rvalid1", req1_rvalid, exp_rv1);
    if (exp_rv0) check("rdata0", req0_rdata, exp_rdata);
    if (exp_rv1) check("rdata1", req1_rdata, exp_rdata);

    if (reset) begin
      exp_rv0   = exp_rd && exp_src == 0;
      exp_rv1   = exp_rd && exp_src == 1;
      exp_rdata = pend_rdata;
      t = (win == 1) ? q1[0] : (win == 0) ? q0[0] : '0;
      exp_wr = (win >= 0) && t.we;
      exp_rd = (win >= 0) && !t.we;
      if (win >= 0) begin
        exp_addr = t.addr; exp_do = t.wdata; exp_src = win;
        if (t.we) shadow[t.addr] = t.wdata;
        else      pend_rdata = shadow[t.addr];
      end
      // Ownership: taken by a locked transfer, lost on an unlocked one or after MAXL locked cycles
      err_now = 1'b0;
      if (owner < 0) begin
        if (win >= 0) begin
          last = win;
          if (t.lock) begin owner = win; lock_cycles = 0; end
        end
      end else begin
        lock_cycles++;
        if (lock_cycles == MAXL) begin
          last = owner; owner = -1; err_now = 1'b1;
        end else if (win >= 0 && !t.lock) begin
          last = owner; owner = -1;
        end
      end
      exp_err = err_now;
    end

    @(posedge clk);
    #1;
    if (reset && win == 0) void'(q0.pop_front());
    if (reset && win == 1) void'(q1.pop_front());
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0); i++) step();
    check("drain", q0.size() + q1.size(), 0);
    q0.delete(); q1.delete();
    repeat (3) step();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) step();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) shadow[i] = init_val(AW'(i));
    pend_rdata = '0;
    exp_rdata  = '0;
    ram_clr = 1'b1;
    reset   = 1'b0;
    model_reset();
    repeat (3) step();
    ram_clr = 1'b0;
    reset   = 1'b1;
    step();

    // Single read of a preloaded word
    q0.push_back(mk(1'b0, 1'b0, 14'h0081, 8'h00));
    drain();

    // Both requesting continuously without lock, from reset
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(i[0], 1'b0, AW'(16'h0100 + i), DW'(8'h10 + i)));
      q1.push_back(mk(1'b0, 1'b0, AW'(16'h0200 + i), 8'h00));
    end
    drain();

    // Four-beat locked read with the other requester waiting
    q0.push_back(mk(1'b0, 1'b1, 14'h0010, 8'h00));
    step();
    q0.push_back(mk(1'b0, 1'b1, 14'h0011, 8'h00));
    q0.push_back(mk(1'b0, 1'b1, 14'h0012, 8'h00));
    q0.push_back(mk(1'b0, 1'b0, 14'h0013, 8'h00));
    q1.push_back(mk(1'b0, 1'b0, 14'h0020, 8'h00));
    drain();

    // Lock held past the limit is forcibly released
    q0.push_back(mk(1'b0, 1'b1, 14'h0030, 8'h00));
    step();
    for (int i = 1; i < 10; i++) q0.push_back(mk(1'b0, 1'b1, AW'(16'h0030 + i), 8'h00));
    q1.push_back(mk(1'b0, 1'b0, 14'h0040, 8'h00));
    drain();

    // Write to the top address alongside a read, then read it back
    q0.push_back(mk(1'b0, 1'b0, 14'h0100, 8'h00));
    q1.push_back(mk(1'b1, 1'b0, 14'h3FFF, 8'hFF));
    drain();
    q0.push_back(mk(1'b0, 1'b0, 14'h3FFF, 8'h00));
    drain();

    // Reset in the cycle after a read transfer
    q0.push_back(mk(1'b0, 1'b0, 14'h0081, 8'h00));
    step();
    reset = 1'b0;
    model_reset();
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    q0.push_back(mk(1'b0, 1'b0, 14'h0001, 8'h00));
    q1.push_back(mk(1'b0, 1'b0, 14'h0002, 8'h00));
    drain();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() == 0 && $urandom_range(3) != 0)
        q0.push_back(mk(1'($urandom), $urandom_range(2) == 0, AW'($urandom), DW'($urandom)));
      if (q1.size() == 0 && $urandom_range(3) != 0)
        q1.push_back(mk(1'($urandom), $urandom_range(2) == 0, AW'($urandom), DW'($urandom)));
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/res_mem_arbiter.md
# res_mem_arbiter

Two-requester arbiter for the single-port result RAM (14-bit address, 8-bit data) used by the distance-transform engine. Lets a second master, the forward/backward pass engine, the host readback, or a debug dump, share the RAM with the main engine without edits to either client. Round-robin arbitration per transfer, with optional lock for multi-beat neighbour fetches. A lock timeout prevents starvation.

## Interface
- ADDR_W, 14, result RAM address width
- DATA_W, 8, result RAM data width
- MAX_LOCK, 8, maximum consecutive cycles a requester may hold the lock (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- reqN_req  in  1  transfer request, N∈{0,1}
- reqN_we  in  1  1=write, 0=read
- reqN_lock  in  1  keep ownership after this transfer
- reqN_addr  in  ADDR_W  RAM address
- reqN_wdata  in  DATA_W  write data
- reqN_gnt  out  1  transfer accepted this cycle (combinational)
- reqN_rvalid  out  1  read data valid
- reqN_rdata  out  DATA_W  read data (= res_di)
- res_wr  out  1  RAM write strobe
- res_rd  out  1  RAM read strobe
- res_addr  out  ADDR_W  RAM address
- res_do  out  DATA_W  RAM write data
- res_di  in  DATA_W  RAM read data, valid the cycle after res_rd
- lock_err  out  1  one-cycle pulse on forced lock release

## Operation
- Transfer occurs on any cycle with reqN_req && reqN_gnt; requester holds req/we/addr/wdata stable until granted.
- States: FREE, LOCK0, LOCK1. rr_last holds the last-granted index.
- FREE: only one requester → grant it. Both → grant index ≠ rr_last. Transfer with lock=1 → LOCKN next cycle, lock_cnt=0. Otherwise stay in FREE.
- LOCKN: only requester N can be granted; other gnt=0. Transfer with lock=0 → FREE. Owner idle (req=0) keeps LOCKN.
- lock_cnt increments every LOCKN cycle. In the cycle lock_cnt==MAX_LOCK-1, the owner may still transfer; next state is FREE regardless of lock, and lock_err pulses in that next cycle.
- Every exit to FREE and every FREE grant sets rr_last=N.
- Registered command: res_wr=we, res_rd=~we, res_addr, res_do update the cycle after a transfer. If no transfer occurs, res_wr=res_rd=0 and res_addr/res_do hold their values.
- reqN_rvalid is registered and asserts the cycle after res_rd for a read issued by N. reqN_rdata=res_di passthrough, meaningful only while rvalid.
- Width: lock_cnt is $clog2(MAX_LOCK) bits and saturates at no value beyond MAX_LOCK-1.

## Timing
- Reset (async, low): state=FREE, rr_last=1 (req0 wins first tie), lock_cnt=0. res_wr=res_rd=0, res_addr=0, res_do=0, rvalid=0, lock_err=0.
- gnt is valid the same cycle as req, derived from state, rr_last and both reqs.
- Read latency is 2 cycles: transfer at t → res_rd/res_addr at t+1 → rvalid/rdata at t+2.
- Write: transfer at t → res_wr at t+1.
- Peak throughput is one transfer per cycle; back-to-back locked reads return in order.
- Simultaneous request and lock release: a lock=0 transfer from owner at t lets the other requester be granted at t+1.
- Reset asserted mid-read: the pending rvalid is dropped, and no RAM strobe is issued after reset deasserts until a new transfer.

## Structure
- Shared package res_arb_pkg: ADDR_W/DATA_W defaults and the state enum (FREE, LOCK0, LOCK1). The RAM geometry constants (128×128 image, 16384 words) belong in this same package for all result-RAM clients.
- No sub-module. Pick logic, FSM and command register stay in one module.

## Test plan
- Single read, req0 at addr 0x0081, RAM holds 5 → gnt0 same cycle, res_rd=1/res_addr=0x0081 next cycle, rvalid0=1 with rdata0=5 one cycle later.
- Both request continuously, no lock, from reset → grants alternate 0,1,0,1; RAM commands alternate accordingly.
- req0 locked 4-beat read (lock=1,1,1,0) with req1 pending → gnt1=0 for all 4 beats, req1 granted the cycle after beat 4, no lock_err.
- req0 holds lock=1 for 10 cycles, MAX_LOCK=8 → forced FREE after 8 cycles, lock_err pulses once, req1 granted on the next cycle.
- Write req1 addr 0x3FFF data 0xFF during read from req0 → data at 0x3FFF reads back 0xFF; rvalid asserts only on the issuing port.
- Reset asserted the cycle after a read transfer → rvalid never asserts, all RAM outputs 0, and the first grant after release goes to req0 on a tie.
